// File: rtl/switch_debounce_encoder.sv
// ---------------------------------------------------------------------------
// switch_debounce_encoder
//
// Front end for the LED 3-to-8 decoder. Eight raw, bouncing push-buttons are
// synchronised, debounced per bit, and priority-encoded into the registered
// switch/enable pair the decoder consumes. The decoder lights an LED only
// when enable == 3'b100, which this block drives while any button is held.
//
// Parameters
//   DB_CYCLES  consecutive cycles a synchronised input must differ from its
//              stable value before the stable value flips (>= 2)
//   DB_W       debounce counter width, must hold DB_CYCLES-1
//   SCAN_DIV   clk cycles per auto-scan step (AUTO_SCAN_EN builds only)
//
// Ports
//   clk      in   1  rising-edge clock
//   rst      in   1  asynchronous, active-high reset
//   btn_raw  in   8  raw buttons, active-high, asynchronous to clk
//   switch   out  3  index of selected LED (registered)
//   enable   out  3  3'b100 = decoder active, 3'b000 = all LEDs off
//   press    out  1  one-cycle pulse when a debounced button rises 0->1
//
// Build option
//   AUTO_SCAN_EN  when defined, an idle keypad (no stable button) shows a
//                 running light: enable = 3'b100 and switch steps 0..7,
//                 one step every SCAN_DIV cycles. Any held button stops the
//                 scan; releasing all buttons restarts it at 0. Undefined:
//                 idle gives enable = 3'b000 and switch holds its value.
//
// Latency: a raw change held steady shows on switch/enable/press at rising
// edge DB_CYCLES+3 after the first edge that samples it.
// ---------------------------------------------------------------------------
module switch_debounce_encoder #(
  parameter int DB_CYCLES = 8,
  parameter int DB_W      = 4,
  parameter int SCAN_DIV  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] btn_raw,
  output logic [2:0] switch,
  output logic [2:0] enable,
  output logic       press
);

  // Reject configurations the counters cannot represent.
  if (DB_CYCLES < 2 || (DB_CYCLES - 1) >= (1 << DB_W) || SCAN_DIV < 1) begin : g_param_check
    $error("switch_debounce_encoder: illegal DB_CYCLES/DB_W/SCAN_DIV");
  end

  localparam logic [DB_W-1:0] CNT_LAST = DB_W'(DB_CYCLES - 1);

  logic [7:0]      s1;
  logic [7:0]      s2;
  logic [7:0]      stable;
  logic [7:0]      stable_d;   // stable as seen by the output stage last cycle
  logic [DB_W-1:0] cnt [8];
  logic            any_set;
  logic [2:0]      enc_idx;

  // Two-flop synchroniser per button; btn_raw has no timing relation to clk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: sequential state is always assigned with <= so every flop
      // samples the pre-edge value of its source, regardless of statement order.
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= btn_raw;
      s2 <= s1;
    end
  end

  // Per-bit debounce. The count only advances while s2 disagrees with the
  // stable value; a single agreeing sample restarts it, so press and release
  // both need DB_CYCLES uninterrupted samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stable <= '0;
      // NOTE: the counter array is eight small flop registers, not a RAM, so
      // it is reset like any other state; a reset mid-debounce drops partial counts.
      for (int i = 0; i < 8; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (s2[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          stable[i] <= ~stable[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  // Priority encoder: the highest-numbered held button wins.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    any_set = |stable;
    enc_idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (stable[i]) begin
        enc_idx = 3'(i);
      end
    end
  end

`ifdef AUTO_SCAN_EN
  localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

  logic [SCAN_W-1:0] scan_cnt;
  logic [2:0]        scan_pos;

  // Running-light position; held at 0 whenever a button is stable so the
  // scan always restarts from LED 0 after the last release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_cnt <= '0;
      scan_pos <= '0;
    end else if (any_set) begin
      scan_cnt <= '0;
      scan_pos <= '0;
    end else if (scan_cnt == SCAN_LAST) begin
      scan_cnt <= '0;
      scan_pos <= scan_pos + 3'd1;   // wraps 7 -> 0
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
    end
  end
`endif

  // Output stage. press compares stable against the copy the output stage
  // saw last cycle, so the pulse lands in the same cycle switch/enable take
  // the new stable value. Releases clear bits and therefore never pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stable_d <= '0;
      switch   <= '0;
      enable   <= '0;
      press    <= 1'b0;
    end else begin
      stable_d <= stable;
      press    <= |(stable & ~stable_d);
      if (any_set) begin
        switch <= enc_idx;
        enable <= 3'b100;
      end else begin
`ifdef AUTO_SCAN_EN
        switch <= scan_pos;
        enable <= 3'b100;
`else
        enable <= 3'b000;   // switch keeps the last selected index
`endif
      end
    end
  end

endmodule
